// File: rtl/acl_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : acl_sample_fifo
//  Brief    : Synchronises and de-glitches the 15-bit accelerometer word
//             {x[14:10], y[9:5], z[4:0]}, queues each new stable sample in a
//             FIFO and exposes it as DATA/STATUS/CTRL words in dmem space.
//  Options  : ACL_AVG_EN - push the truncated mean of every 4 accepted
//             samples instead of every accepted sample.
//  Revision : 1.0 - initial release
// ============================================================================
module acl_sample_fifo #(
  parameter int          DEPTH         = 8,
  parameter int          STABLE_CYCLES = 4,
  parameter logic [11:0] BASE_ADDR     = 12'hFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] acl_data,
  input  logic [11:0] bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [31:0] bus_wdata,
  output logic        bus_hit,
  output logic [31:0] bus_rdata,
  output logic        acl_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [14:0]   sync1, sync2, cand, last_pushed;
  logic [SW-1:0] stab_cnt;
  logic          enable, overflow;
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic          overflow_n, enable_n;
  logic [14:0]   mem [DEPTH];

  logic          accept, push_valid, do_push, pop, flush, ctrl_wr;
  logic          sel_data, sel_stat, sel_ctrl, empty, full;
  logic [14:0]   push_data;
  logic [7:0]    count_byte;
  logic          unused_wdata;

  // Address decode; compare in 13 bits so BASE_ADDR near 12'hFFF cannot wrap
  assign bus_hit  = ({1'b0, bus_addr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, bus_addr} <= ({1'b0, BASE_ADDR} + 13'd2));
  assign sel_data = bus_hit && (bus_addr == BASE_ADDR);
  assign sel_stat = bus_hit && (bus_addr == BASE_ADDR + 12'd1);
  assign sel_ctrl = bus_hit && (bus_addr == BASE_ADDR + 12'd2);

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign pop        = bus_rd && sel_data && !empty;
  assign ctrl_wr    = bus_wr && sel_ctrl;
  assign flush      = ctrl_wr && bus_wdata[1];
  assign count_byte = 8'(count);
  assign unused_wdata = ^bus_wdata[31:2];

  // A sample qualifies once it has been stable long enough and differs from the last one taken
  assign accept = (stab_cnt == STAB_MAX) && (cand != last_pushed) && enable;

  // Two-flop synchroniser plus stability tracking (continues even while disabled)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1       <= '0;
      sync2       <= '0;
      cand        <= '0;
      stab_cnt    <= '0;
      last_pushed <= '0;
    end else begin
      sync1 <= acl_data;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand     <= sync2;
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end
      if (accept) last_pushed <= cand;
    end
  end

`ifdef ACL_AVG_EN
  logic [6:0] sum_x, sum_y, sum_z, nx, ny, nz;
  logic [1:0] acc_cnt;
  logic       acc_clear;

  assign nx         = sum_x + {2'b00, cand[14:10]};
  assign ny         = sum_y + {2'b00, cand[9:5]};
  assign nz         = sum_z + {2'b00, cand[4:0]};
  assign acc_clear  = flush || (ctrl_wr && enable && !bus_wdata[0]);
  assign push_valid = accept && (acc_cnt == 2'd3) && !acc_clear;
  assign push_data  = {nx[6:2], ny[6:2], nz[6:2]};

  // Per-axis accumulator; the fourth accepted sample emits the mean and restarts
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_x   <= '0;
      sum_y   <= '0;
      sum_z   <= '0;
      acc_cnt <= '0;
    end else if (acc_clear || (accept && acc_cnt == 2'd3)) begin
      sum_x   <= '0;
      sum_y   <= '0;
      sum_z   <= '0;
      acc_cnt <= '0;
    end else if (accept) begin
      sum_x   <= nx;
      sum_y   <= ny;
      sum_z   <= nz;
      acc_cnt <= acc_cnt + 2'd1;
    end
  end
`else
  assign push_valid = accept;
  assign push_data  = cand;
`endif

  // Next-state of FIFO bookkeeping; flush overrides any push or pop in the same cycle
  always_comb begin
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    count_n    = count;
    overflow_n = overflow;
    enable_n   = enable;
    do_push    = 1'b0;
    if (ctrl_wr) enable_n = bus_wdata[0];
    if (flush) begin
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      count_n    = '0;
      overflow_n = 1'b0;
    end else begin
      if (push_valid) begin
        if (!full || pop) do_push = 1'b1;
        else              overflow_n = 1'b1;
      end
      if (do_push) wr_ptr_n = wr_ptr + 1'b1;
      if (pop)     rd_ptr_n = rd_ptr + 1'b1;
      if (do_push && !pop)      count_n = count + 1'b1;
      else if (!do_push && pop) count_n = count - 1'b1;
    end
  end

  // FIFO pointers, flags and interrupt (irq follows the post-update state)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b1;
      acl_irq  <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      overflow <= overflow_n;
      enable   <= enable_n;
      acl_irq  <= enable_n && (count_n != '0);
    end
  end

  // Sample storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Registered read data; holds its value when no hitting read occurs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_rdata <= '0;
    end else if (bus_rd && bus_hit) begin
      if (sel_data)
        bus_rdata <= empty ? 32'h8000_0000 : {17'b0, mem[rd_ptr]};
      else if (sel_stat)
        bus_rdata <= {overflow, 23'b0, count_byte};
      else if (sel_ctrl)
        bus_rdata <= {31'b0, enable};
    end
  end

endmodule
`default_nettype wire
